frame_sample_scheduler: RTL and testbench



---
 rtl/frame_sched_pkg.sv | 21 ++
 rtl/sched_sync_fifo.sv | 76 +++++++
 rtl/frame_sample_scheduler.sv | 167 ++++++++++++++++
 tb/tb_frame_sample_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and default configuration for the frame sample scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } prod_state_e;

  localparam int DEF_WIDTH   = 32'sd18;
  localparam int DEF_DEPTH   = 32'sd4;
  localparam int DEF_TIMEOUT = 32'sd255;

  // Occupancy needs one bit more than the pointers so that "full" is representable.
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  localparam int FILL_W = fill_w(DEF_DEPTH);

endpackage

// File: rtl/sched_sync_fifo.sv
// Single-clock sample FIFO: storage, wrapping pointers, occupancy count and flush.
module sched_sync_fifo
  import frame_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [fill_w(DEPTH)-1:0]  count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fill_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Flush dominates; an out-of-range push or pop is dropped rather than corrupting the count.
  assign push_s = push & ~full & ~flush;
  assign pop_s  = pop & ~empty & ~flush;

  // Sample storage write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy move together so count always matches the pointer distance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_FULL);

endmodule

// File: rtl/frame_sample_scheduler.sv
// Requests samples from the generator, buffers them, and releases one per codec frame.
// Define SAMPLE_HOLD_EN to repeat the previous sample on underrun instead of emitting silence.
module frame_sample_scheduler
  import frame_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      new_frame,
  output logic                      gen_req,
  input  logic                      gen_valid,
  input  logic [WIDTH-1:0]          gen_sample,
  output logic [WIDTH-1:0]          codec_sample,
  output logic                      codec_valid,
  output logic [fill_w(DEPTH)-1:0]  fill_level,
  output logic                      underrun,
  output logic                      timeout_err,
  input  logic                      clear_flags
);

  localparam int TMR_W = $clog2(TIMEOUT + 32'sd1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 32'sd1);

  prod_state_e      state_r;
  prod_state_e      state_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_s;
  logic             gen_req_r;
  logic [WIDTH-1:0] codec_sample_r;
  logic             codec_valid_r;
  logic             underrun_r;
  logic             timeout_err_r;

  logic             push_s;
  logic             pop_s;
  logic             timeout_set_s;
  logic             underrun_set_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [WIDTH-1:0] underrun_value_s;

  sched_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (~enable),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (gen_sample),
    .rdata (fifo_head_s),
    .count (fill_level),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // A pop that meets an empty FIFO is the underrun case, even if a push lands the same cycle.
  assign pop_s          = new_frame & enable & ~fifo_empty_s;
  assign underrun_set_s = new_frame & enable & fifo_empty_s;

`ifdef SAMPLE_HOLD_EN
  assign underrun_value_s = codec_sample_r;
`else
  assign underrun_value_s = '0;
`endif

  // Producer next-state: one outstanding request at a time, abandoned after TIMEOUT idle cycles
  always_comb begin
    state_s       = state_r;
    timer_s       = timer_r;
    push_s        = 1'b0;
    timeout_set_s = 1'b0;
    if (!enable) begin
      state_s = IDLE;
      timer_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_full_s) begin
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end
        REQ: begin
          timer_s = '0;
          state_s = WAIT;
        end
        WAIT: begin
          if (gen_valid) begin
            push_s  = 1'b1;
            state_s = IDLE;
          end else if (timer_r == TMR_LAST) begin
            timer_s       = timer_r + TMR_W'(1);
            timeout_set_s = 1'b1;
            state_s       = IDLE;
          end else begin
            timer_s = timer_r + TMR_W'(1);
            state_s = WAIT;
          end
        end
        default: begin
          state_s = IDLE;
          timer_s = '0;
        end
      endcase
    end
  end

  // Producer state, timer and the request strobe (high exactly while in REQ)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      gen_req_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      gen_req_r <= (state_s == REQ);
    end
  end

  // Codec-side output register and sticky health flags; clearing beats a same-cycle set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      codec_sample_r <= '0;
      codec_valid_r  <= 1'b0;
      underrun_r     <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      codec_valid_r <= new_frame;
      if (new_frame) begin
        if (!enable) begin
          codec_sample_r <= '0;
        end else if (!fifo_empty_s) begin
          codec_sample_r <= fifo_head_s;
        end else begin
          codec_sample_r <= underrun_value_s;
        end
      end
      if (clear_flags) begin
        underrun_r    <= 1'b0;
        timeout_err_r <= 1'b0;
      end else begin
        if (underrun_set_s) begin
          underrun_r <= 1'b1;
        end
        if (timeout_set_s) begin
          timeout_err_r <= 1'b1;
        end
      end
    end
  end

  assign gen_req      = gen_req_r;
  assign codec_sample = codec_sample_r;
  assign codec_valid  = codec_valid_r;
  assign underrun     = underrun_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_frame_sample_scheduler.sv
// Directed bench for frame_sample_scheduler with a queue-based reference model checked every cycle.
module tb_frame_sample_scheduler;

  localparam int W = 18;
  localparam int D = 4;
  localparam int T = 255;
`ifdef SAMPLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         new_frame = 1'b0;
  logic         gen_valid = 1'b0;
  logic         clear_flags = 1'b0;
  logic [W-1:0] gen_sample = '0;
  logic         gen_req;
  logic         codec_valid;
  logic         underrun;
  logic         timeout_err;
  logic [W-1:0] codec_sample;
  logic [2:0]   fill_level;

  frame_sample_scheduler #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .new_frame    (new_frame),
    .gen_req      (gen_req),
    .gen_valid    (gen_valid),
    .gen_sample   (gen_sample),
    .codec_sample (codec_sample),
    .codec_valid  (codec_valid),
    .fill_level   (fill_level),
    .underrun     (underrun),
    .timeout_err  (timeout_err),
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: what the outputs must be during the current cycle.
  logic [W-1:0] mq[$];
  bit           m_req = 1'b0;
  bit           m_pend = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_smp = '0;
  bit           m_val = 1'b0;
  bit           m_und = 1'b0;
  bit           m_to = 1'b0;

  // Generator emulation: answers a request two cycles after it is seen.
  bit           auto_resp = 1'b0;
  int           cd = 0;
  logic [W-1:0] next_smp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs present before that edge.
  task automatic model_step();
    int  sz0;
    bit  uset;
    bit  tset;
    if (!reset) begin
      mq.delete();
      m_req = 1'b0; m_pend = 1'b0; m_wait = 0;
      m_smp = '0; m_val = 1'b0; m_und = 1'b0; m_to = 1'b0;
      return;
    end
    sz0  = mq.size();
    uset = 1'b0;
    tset = 1'b0;
    m_val = new_frame;
    if (new_frame) begin
      if (!enable) m_smp = '0;
      else if (sz0 > 0) m_smp = mq.pop_front();
      else begin
        uset = 1'b1;
        if (!HOLD) m_smp = '0;
      end
    end
    if (!enable) begin
      mq.delete();
      m_req = 1'b0; m_pend = 1'b0; m_wait = 0;
    end else if (m_req) begin
      m_req = 1'b0; m_pend = 1'b1; m_wait = 0;
    end else if (m_pend) begin
      if (gen_valid) begin
        mq.push_back(gen_sample);
        m_pend = 1'b0;
      end else begin
        m_wait++;
        if (m_wait == T) begin
          tset = 1'b1;
          m_pend = 1'b0;
        end
      end
    end else begin
      m_req = (sz0 < D);
    end
    if (clear_flags) begin
      m_und = 1'b0; m_to = 1'b0;
    end else begin
      if (uset) m_und = 1'b1;
      if (tset) m_to = 1'b1;
    end
  endtask

  task automatic compare();
    check("gen_req", gen_req, m_req);
    check("codec_sample", codec_sample, m_smp);
    check("codec_valid", codec_valid, m_val);
    check("fill_level", fill_level, 32'(mq.size()));
    check("underrun", underrun, m_und);
    check("timeout_err", timeout_err, m_to);
  endtask

  task automatic respond();
    gen_valid = 1'b0;
    if (!reset) cd = 0;
    else if (cd == 1) begin
      gen_valid = 1'b1;
      gen_sample = next_smp;
      next_smp = next_smp + 18'd1;
      cd = 0;
    end else if (cd > 1) cd--;
    if (reset && auto_resp && gen_req) cd = 2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    compare();
    respond();
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic flush_now();
    enable = 1'b0;
    cd = 0;
    tick();
  endtask

  initial begin
    int c;
    int n;
    #1 reset = 1'b0;
    repeat (3) tick();
    check("reset_outs", {gen_req, codec_valid, underrun, timeout_err, fill_level, codec_sample}, 32'd0);

    // Fill from reset: four requests, then the FIFO is full and requesting stops.
    reset = 1'b1; enable = 1'b1; auto_resp = 1'b1; next_smp = 18'd1;
    c = 0;
    repeat (30) begin tick(); c += int'(gen_req); end
    check("fill_req_count", c, 32'd4);
    check("fill_full", fill_level, 32'd4);

    // Frames pop in order, each pop triggers one refill request.
    repeat (9) tick();
    frame();
    check("pop1_sample", codec_sample, 32'd1);
    check("pop1_valid", codec_valid, 32'd1);
    c = 0;
    repeat (9) begin tick(); c += int'(gen_req); end
    check("refill_req_count", c, 32'd1);
    check("held_sample", codec_sample, 32'd1);
    check("valid_is_pulse", codec_valid, 32'd0);
    frame();
    check("pop2_sample", codec_sample, 32'd2);

    // Underrun on an empty FIFO, then a silent generator times out.
    auto_resp = 1'b0;
    flush_now();
    check("flush_level", fill_level, 32'd0);
    enable = 1'b1;
    frame();
    check("underrun_sample", codec_sample, 32'd0);
    check("underrun_valid", codec_valid, 32'd1);
    check("underrun_flag", underrun, 32'd1);
    n = 0;
    while (!gen_req && n < 10) begin tick(); n++; end
    check("req_before_timeout", gen_req, 32'd1);
    n = 0;
    while (!timeout_err && n < 300) begin tick(); n++; end
    check("timeout_latency", n, 32'd256);
    check("underrun_sticky", underrun, 32'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("clear_underrun", underrun, 32'd0);
    check("clear_timeout", timeout_err, 32'd0);

    // Push and pop in the same cycle with two entries queued.
    flush_now();
    enable = 1'b1; auto_resp = 1'b1; next_smp = 18'd10;
    n = 0;
    while (!(gen_valid && fill_level == 3'd2) && n < 40) begin tick(); n++; end
    check("pushpop_setup", {gen_valid, fill_level}, {1'b1, 3'd2});
    frame();
    check("pushpop_level", fill_level, 32'd2);
    check("pushpop_head", codec_sample, 32'd10);
    frame();
    check("order_2nd", codec_sample, 32'd11);
    frame();
    check("order_pushed", codec_sample, 32'd12);

    // Abort a pending request by dropping enable; late responses are discarded.
    flush_now();
    enable = 1'b1; auto_resp = 1'b1; next_smp = 18'd20;
    n = 0;
    while (fill_level != 3'd3 && n < 40) begin tick(); n++; end
    auto_resp = 1'b0;
    n = 0;
    while (!gen_req && n < 10) begin tick(); n++; end
    check("abort_req_seen", gen_req, 32'd1);
    tick();
    enable = 1'b0;
    tick();
    check("abort_flush", fill_level, 32'd0);
    gen_valid = 1'b1; gen_sample = 18'h3ffff;
    tick();
    c = 0;
    repeat (6) begin tick(); c += int'(gen_req); end
    check("disabled_no_req", c, 32'd0);
    check("late_discard", fill_level, 32'd0);
    frame();
    check("disabled_frame_sample", codec_sample, 32'd0);
    check("disabled_frame_valid", codec_valid, 32'd1);
    check("disabled_no_underrun", underrun, 32'd0);
    enable = 1'b1;
    gen_valid = 1'b1; gen_sample = 18'h2aaaa;
    tick();
    check("idle_valid_ignored", fill_level, 32'd0);

    // Underrun value after a real sample: silence, or the held sample when enabled.
    flush_now();
    enable = 1'b1; auto_resp = 1'b1; next_smp = 18'h00123;
    n = 0;
    while (fill_level != 3'd1 && n < 20) begin tick(); n++; end
    auto_resp = 1'b0;
    frame();
    check("last_sample", codec_sample, 32'h00123);
    frame();
    check("underrun_value", codec_sample, HOLD ? 32'h00123 : 32'd0);
    check("underrun_value_valid", codec_valid, 32'd1);
    check("underrun_value_flag", underrun, 32'd1);

    // Asynchronous reset in the middle of a wait.
    tick();
    reset = 1'b0;
    #1;
    check("reset_async", {gen_req, codec_valid, underrun, timeout_err, fill_level, codec_sample}, 32'd0);
    c = 0;
    repeat (5) begin tick(); c += int'(gen_req); end
    check("reset_no_req", c, 32'd0);
    reset = 1'b1;
    tick();
    check("post_reset_req", gen_req, 32'd1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
